// File: rtl/memory_package.sv
// rtl/memory_package.sv - size codes, FSM states and lane extract/merge helpers for the load/store unit
package memory_package;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_RESPOND
    } state_t;

    // Little-endian lanes: byte n at [8n+7:8n], half h at [16h+15:16h].
    function automatic logic [31:0] extract_lane(input logic [31:0] data,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{offset, 3'b000} +: 8];
        h = offset[1] ? data[31:16] : data[15:0];
        case (size)
            SIZE_BYTE: return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default:   return data;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] new_data,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size);
        logic [31:0] result;
        result = old_word;
        case (size)
            SIZE_BYTE: result[{offset, 3'b000} +: 8] = new_data[7:0];
            SIZE_HALF: begin
                if (offset[1]) result[31:16] = new_data[15:0];
                else           result[15:0]  = new_data[15:0];
            end
            default:   result = new_data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lane_extract.sv
// rtl/lane_extract.sv - combinational lane select with sign/zero extension
module lane_extract
    import memory_package::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    assign value = extract_lane(data, offset, size, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator with read-modify-write sub-word stores
module load_store_unit
    import memory_package::*;
#(
    parameter int unsigned MEMORY_SIZE_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        request_write,
    input  logic [1:0]  request_size,
    input  logic        request_unsigned,
    input  logic [31:0] request_address,
    input  logic [31:0] request_data,
    output logic        response_valid,
    output logic [31:0] response_data,
    output logic        response_error,
    output logic [31:0] memory_address,
    output logic [31:0] memory_input_data,
    output logic        memory_should_write,
    input  logic [31:0] memory_output_data
);

    state_t      state, next_state;
    logic        held_write;
    logic [1:0]  held_size;
    logic        held_unsigned;
    logic [31:0] held_address;
    logic [31:0] held_data;
    logic        fault;
    logic        accept;
    logic [31:0] load_value;

    assign accept = (state == ST_IDLE) && request_valid;

    always_comb begin
        fault = 1'b0;
        case (request_size)
            SIZE_HALF:    fault = request_address[0];
            SIZE_WORD:    fault = (request_address[1:0] != 2'b00);
            SIZE_ILLEGAL: fault = 1'b1;
            default:      fault = 1'b0;
        endcase
        if ({2'b00, request_address[31:2]} >= 32'(MEMORY_SIZE_WORDS))
            fault = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (request_valid) begin
                    if (fault)                                       next_state = ST_RESPOND;
                    else if (request_write && request_size == SIZE_WORD) next_state = ST_WRITE;
                    else                                             next_state = ST_READ;
                end
            end
            ST_READ:    next_state = held_write ? ST_MERGE : ST_LOAD;
            ST_LOAD:    next_state = ST_RESPOND;
            ST_MERGE:   next_state = ST_RESPOND;
            ST_WRITE:   next_state = ST_RESPOND;
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_write     <= 1'b0;
            held_size      <= SIZE_BYTE;
            held_unsigned  <= 1'b0;
            held_address   <= '0;
            held_data      <= '0;
            response_data  <= '0;
            response_error <= 1'b0;
        end else if (accept) begin
            held_write     <= request_write;
            held_size      <= request_size;
            held_unsigned  <= request_unsigned;
            held_address   <= request_address;
            held_data      <= request_data;
            response_data  <= '0;
            response_error <= fault;
        end else if (state == ST_LOAD) begin
            response_data  <= load_value;
        end
    end

    lane_extract u_lane_extract (
        .data        (memory_output_data),
        .offset      (held_address[1:0]),
        .size        (held_size),
        .is_unsigned (held_unsigned),
        .value       (load_value)
    );

    // Ready is gated by reset_n so it stays low for the whole time reset is held.
    assign request_ready       = reset_n && (state == ST_IDLE);
    assign response_valid      = (state == ST_RESPOND);
    assign memory_address      = {held_address[31:2], 2'b00};
    assign memory_should_write = (state == ST_MERGE) || (state == ST_WRITE);

    always_comb begin
        memory_input_data = '0;
        if (state == ST_MERGE)
            memory_input_data = merge_lane(memory_output_data, held_data, held_address[1:0], held_size);
        else if (state == ST_WRITE)
            memory_input_data = held_data;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        request_valid = 1'b0;
    logic        request_ready;
    logic        request_write = 1'b0;
    logic [1:0]  request_size = 2'b00;
    logic        request_unsigned = 1'b0;
    logic [31:0] request_address = '0;
    logic [31:0] request_data = '0;
    logic        response_valid;
    logic [31:0] response_data;
    logic        response_error;
    logic [31:0] memory_address;
    logic [31:0] memory_input_data;
    logic        memory_should_write;
    logic [31:0] memory_output_data = '0;

    logic [31:0] mem [256];
    int          wr_total = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    // Memory: read data registered on the rising edge, writes commit on the falling edge.
    always @(posedge clock) memory_output_data <= mem[memory_address[9:2]];
    always @(negedge clock) begin
        if (memory_should_write) begin
            mem[memory_address[9:2]] <= memory_input_data;
            wr_total <= wr_total + 1;
        end
    end

    load_store_unit #(.MEMORY_SIZE_WORDS(256)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .request_valid       (request_valid),
        .request_ready       (request_ready),
        .request_write       (request_write),
        .request_size        (request_size),
        .request_unsigned    (request_unsigned),
        .request_address     (request_address),
        .request_data        (request_data),
        .response_valid      (response_valid),
        .response_data       (response_data),
        .response_error      (response_error),
        .memory_address      (memory_address),
        .memory_input_data   (memory_input_data),
        .memory_should_write (memory_should_write),
        .memory_output_data  (memory_output_data)
    );

    // Issues one request and returns the response plus latency (99 = no response) and write-strobe count.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic rerr,
                           output int lat, output int writes);
        int w0;
        @(negedge clock);
        request_write = wr; request_size = sz; request_unsigned = uns;
        request_address = addr; request_data = data; request_valid = 1'b1;
        @(posedge clock);
        #1 request_valid = 1'b0;
        w0 = wr_total;
        lat = 99; rdata = 'x; rerr = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (response_valid) begin
                lat = i; rdata = response_data; rerr = response_error;
                break;
            end
        end
        #2 writes = wr_total - w0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (request_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", request_ready); end
        checks++; if (response_valid !== 1'b0 || response_error !== 1'b0 || response_data !== 32'h0) begin
            errors++; $display("FAIL reset_response got v=%b e=%b d=%h want 0", response_valid, response_error, response_data); end
        checks++; if (memory_should_write !== 1'b0 || memory_address !== 32'h0 || memory_input_data !== 32'h0) begin
            errors++; $display("FAIL reset_memory got w=%b a=%h d=%h want 0", memory_should_write, memory_address, memory_input_data); end
        reset_n = 1'b1;
        #1;
        checks++; if (request_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", request_ready); end
    endtask

    task automatic test_word_store;
        logic [31:0] d; logic e; int lat, w;
        run_req(1'b1, SZ_W, 1'b0, 32'h10, 32'h8899AABB, d, e, lat, w);
        checks++; if (lat !== 2 || w !== 1 || e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL store_word_10 got lat=%0d wr=%0d err=%b data=%h want 2 1 0 0", lat, w, e, d); end
        run_req(1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678, d, e, lat, w);
        checks++; if (lat !== 2 || w !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL store_word_20 got lat=%0d wr=%0d err=%b want 2 1 0", lat, w, e); end
        run_req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, d, e, lat, w);
        checks++; if (d !== 32'h12345678 || e !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL readback_word_20 got data=%h lat=%0d want 12345678 3", d, lat); end
    endtask

    task automatic test_loads;
        logic [31:0] addrs [5] = '{32'h13, 32'h10, 32'h11, 32'h11, 32'h12};
        logic [1:0]  sizes [5] = '{SZ_B, SZ_H, SZ_B, SZ_B, SZ_H};
        logic        unss  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [5] = '{32'hFFFFFF88, 32'h0000AABB, 32'h000000AA, 32'hFFFFFFAA, 32'hFFFF8899};
        logic [31:0] d; logic e; int lat, w;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, d, e, lat, w);
            checks++; if (d !== exps[i] || e !== 1'b0 || lat !== 3 || w !== 0) begin
                errors++; $display("FAIL load_%0d got data=%h err=%b lat=%0d wr=%0d want %h 0 3 0", i, d, e, lat, w, exps[i]); end
        end
    endtask

    task automatic test_subword_store;
        logic [31:0] d; logic e; int lat, w;
        run_req(1'b1, SZ_H, 1'b0, 32'h12, 32'hDEADBEEF, d, e, lat, w);
        checks++; if (lat !== 3 || w !== 1 || e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL store_half_12 got lat=%0d wr=%0d err=%b data=%h want 3 1 0 0", lat, w, e, d); end
        run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, d, e, lat, w);
        checks++; if (d !== 32'hBEEFAABB) begin errors++; $display("FAIL merge_half got=%h want=beefaabb", d); end
        run_req(1'b1, SZ_B, 1'b0, 32'h11, 32'h1234565A, d, e, lat, w);
        checks++; if (lat !== 3 || w !== 1) begin errors++; $display("FAIL store_byte_11 got lat=%0d wr=%0d want 3 1", lat, w); end
        run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, d, e, lat, w);
        checks++; if (d !== 32'hBEEF5ABB) begin errors++; $display("FAIL merge_byte got=%h want=beef5abb", d); end
    endtask

    task automatic test_faults;
        logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sizes [4] = '{SZ_W, SZ_H, SZ_X, SZ_W};
        logic [31:0] addrs [4] = '{32'h06, 32'h11, 32'h10, 32'h400};
        logic [31:0] d; logic e; int lat, w;
        for (int i = 0; i < 4; i++) begin
            run_req(wrs[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF, d, e, lat, w);
            checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1 || w !== 0) begin
                errors++; $display("FAIL fault_%0d got err=%b data=%h lat=%0d wr=%0d want 1 0 1 0", i, e, d, lat, w); end
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d; logic e; int lat, w, w0; logic seen;
        @(negedge clock);
        request_write = 1'b1; request_size = SZ_B; request_unsigned = 1'b0;
        request_address = 32'h20; request_data = 32'h77; request_valid = 1'b1;
        @(posedge clock);
        #1 request_valid = 1'b0;
        w0 = wr_total;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (request_ready !== 1'b0 || response_valid !== 1'b0 || memory_should_write !== 1'b0) begin
            errors++; $display("FAIL midflight_ctrl got rdy=%b v=%b w=%b want 0 0 0", request_ready, response_valid, memory_should_write); end
        checks++; if (memory_address !== 32'h0 || memory_input_data !== 32'h0 || response_data !== 32'h0) begin
            errors++; $display("FAIL midflight_data got a=%h d=%h r=%h want 0", memory_address, memory_input_data, response_data); end
        seen = 1'b0;
        repeat (3) begin @(negedge clock); if (response_valid) seen = 1'b1; end
        reset_n = 1'b1;
        #1;
        checks++; if (request_ready !== 1'b1 || seen !== 1'b0 || wr_total != w0) begin
            errors++; $display("FAIL midflight_after got rdy=%b resp=%b wr=%0d want 1 0 0", request_ready, seen, wr_total - w0); end
        run_req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, d, e, lat, w);
        checks++; if (d !== 32'h12345678 || e !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL midflight_load got data=%h lat=%0d want 12345678 3", d, lat); end
    endtask

    task automatic test_back_to_back;
        logic busy_ready; int gap; logic got1, got2;
        @(negedge clock);
        request_write = 1'b0; request_size = SZ_W; request_unsigned = 1'b0;
        request_address = 32'h10; request_data = 32'h0; request_valid = 1'b1;
        @(posedge clock);
        #1;
        busy_ready = 1'b0; got1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (request_ready) busy_ready = 1'b1;
            if (response_valid) begin
                got1 = 1'b1;
                checks++; if (response_data !== 32'hBEEF5ABB || i !== 2) begin
                    errors++; $display("FAIL b2b_first got data=%h lat=%0d want beef5abb 3", response_data, i + 1); end
                break;
            end
        end
        request_address = 32'h20;
        checks++; if (busy_ready !== 1'b0 || got1 !== 1'b1) begin
            errors++; $display("FAIL b2b_busy got ready_seen=%b resp=%b want 0 1", busy_ready, got1); end
        @(negedge clock);
        checks++; if (request_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b want=1", request_ready); end
        @(posedge clock);
        #1 request_valid = 1'b0;
        gap = 99; got2 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (response_valid) begin
                got2 = 1'b1; gap = i;
                checks++; if (response_data !== 32'h12345678) begin
                    errors++; $display("FAIL b2b_second_data got=%h want=12345678", response_data); end
                break;
            end
        end
        checks++; if (gap !== 3 || got2 !== 1'b1) begin errors++; $display("FAIL b2b_second_latency got=%0d want=3", gap); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_faults();
        test_reset_midflight();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
